iterative_alu: RTL and testbench

//  Consumer end of the 3-bit ALU control code: executes the operation selected
//  by ALUCtrl_i on two operands. AND/OR/ADD/SUB complete in one cycle; MUL uses
//  an iterative radix-2 shift-add multiplier. Sits in EX; busy_o feeds the

---
 rtl/iterative_alu_if.sv | 26 ++
 rtl/iterative_alu.sv | 127 ++++++++++++
 tb/tb_iterative_alu.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_alu_if.sv
// Handshake and data bundle between the EX-stage issuer and iterative_alu.
// The master drives operands and control; the slave returns result and status.
interface iterative_alu_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_i;
  logic             flush_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;

  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i, flush_i,
    input  ready_o, valid_o, data_o, zero_o, busy_o
  );

  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i, flush_i,
    output ready_o, valid_o, data_o, zero_o, busy_o
  );
endinterface

// File: rtl/iterative_alu.sv
// ALU with single-cycle AND/OR/ADD/SUB and an iterative radix-2 shift-add MUL.
// Optional macro MUL_EARLY_TERM_EN: MUL finishes as soon as the multiplier register empties.
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  iterative_alu_if.slave bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [6:0] CNT_LAST = 7'(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [6:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             zero_reg, zero_next;
  logic             valid_reg, valid_next;

  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] b_shift;
  logic             mul_done;

  // Unassigned codes (including MUL, which never takes this path) yield zero.
  always_comb begin
    alu_result = '0;
    case (bus.ALUCtrl_i)
      OP_AND:  alu_result = bus.data1_i & bus.data2_i;
      OP_OR:   alu_result = bus.data1_i | bus.data2_i;
      OP_ADD:  alu_result = bus.data1_i + bus.data2_i;
      OP_SUB:  alu_result = bus.data1_i - bus.data2_i;
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    acc_sum = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    b_shift = b_reg >> 1;
`ifdef MUL_EARLY_TERM_EN
    mul_done = ((cnt_reg + 7'd1) == CNT_LAST) || (b_shift == '0);
`else
    mul_done = ((cnt_reg + 7'd1) == CNT_LAST);
`endif
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    zero_next  = zero_reg;
    valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.flush_i && bus.valid_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            a_next     = bus.data1_i;
            b_next     = bus.data2_i;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = MUL;
          end else begin
            data_next  = alu_result;
            zero_next  = (alu_result == '0);
            valid_next = 1'b1;
          end
        end
      end
      MUL: begin
        if (bus.flush_i) begin
          state_next = IDLE;
        end else begin
          acc_next = acc_sum;
          a_next   = a_reg << 1;
          b_next   = b_shift;
          cnt_next = cnt_reg + 7'd1;
          if (mul_done) begin
            data_next  = acc_sum;
            zero_next  = (acc_sum == '0);
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      zero_reg  <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      zero_reg  <= zero_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.ready_o = (state_reg == IDLE);
  assign bus.busy_o  = (state_reg == MUL);
  assign bus.valid_o = valid_reg;
  assign bus.data_o  = data_reg;
  assign bus.zero_o  = zero_reg;
endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu at WIDTH=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_iterative_alu;
  localparam int W = 32;

`ifdef MUL_EARLY_TERM_EN
  localparam logic [31:0] B_ABORT = 32'h4000_0007;
  localparam int LAT_3X5  = 3;
  localparam int LAT_BZ   = 1;
`else
  localparam logic [31:0] B_ABORT = 32'd7;
  localparam int LAT_3X5  = 32;
  localparam int LAT_BZ   = 32;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iterative_alu_if #(.WIDTH(W)) bus ();

  iterative_alu #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.ALUCtrl_i = 3'b000;
    bus.data1_i = '0; bus.data2_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 ||
        bus.data_o !== 32'd0 || bus.zero_o !== 1'b1) begin
      failures++;
      $display("FAIL reset: ready=%b busy=%b valid=%b data=%h zero=%b, required 1 0 0 00000000 1",
               bus.ready_o, bus.busy_o, bus.valid_o, bus.data_o, bus.zero_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_cycle();
    logic [2:0]  ops [8] = '{3'b010, 3'b110, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] av  [8] = '{32'd7, 32'd5, 32'd9, 32'hF0F0_1234, 32'hF0F0_0000, 32'd3, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bv  [8] = '{32'd5, 32'd7, 32'd9, 32'h0FF0_FF00, 32'h0000_00FF, 32'd4, 32'd4, 32'd1};
    logic [31:0] ev  [8] = '{32'd12, 32'hFFFF_FFFE, 32'd0, 32'h00F0_1200, 32'hF0F0_00FF, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      bus.ALUCtrl_i = ops[i]; bus.data1_i = av[i]; bus.data2_i = bv[i];
      bus.valid_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== ev[i] || bus.zero_o !== (ev[i] == 32'd0)) begin
        failures++;
        $display("FAIL single op=%b a=%h b=%h: valid=%b data=%h zero=%b, required 1 %h %b",
                 ops[i], av[i], bv[i], bus.valid_o, bus.data_o, bus.zero_o, ev[i], ev[i] == 32'd0);
      end
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b0 || bus.data_o !== ev[i]) begin
        failures++;
        $display("FAIL single_hold op=%b: valid=%b data=%h, required 0 %h",
                 ops[i], bus.valid_o, bus.data_o, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4] = '{3'b010, 3'b110, 3'b001, 3'b000};
    logic [31:0] av  [4] = '{32'd100, 32'd100, 32'h00FF_0000, 32'hAAAA_AAAA};
    logic [31:0] bv  [4] = '{32'd23, 32'd1, 32'h0000_FF00, 32'h5555_5555};
    logic [31:0] ev  [4] = '{32'd123, 32'd99, 32'h00FF_FF00, 32'd0};
    bus.valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ALUCtrl_i = ops[i]; bus.data1_i = av[i]; bus.data2_i = bv[i];
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== ev[i] || bus.zero_o !== (ev[i] == 32'd0)) begin
        failures++;
        $display("FAIL b2b[%0d]: valid=%b data=%h zero=%b, required 1 %h %b",
                 i, bus.valid_o, bus.data_o, bus.zero_o, ev[i], ev[i] == 32'd0);
      end
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] av  [3] = '{32'd3, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] bv  [3] = '{32'd5, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] ev  [3] = '{32'd15, 32'd1, 32'd0};
    int          lat [3] = '{LAT_3X5, 32, LAT_BZ};
    int n;
    int busy_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.ALUCtrl_i = 3'b111; bus.data1_i = av[i]; bus.data2_i = bv[i];
      bus.valid_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      n = 0; busy_cnt = 0;
      while (bus.valid_o !== 1'b1 && n < 200) begin
        if (bus.busy_o === 1'b1 && bus.ready_o === 1'b0) busy_cnt++;
        if (i == 1 && n == 4) begin
          bus.ALUCtrl_i = 3'b010; bus.data1_i = 32'd1; bus.data2_i = 32'd1;
          bus.valid_i = 1'b1;
        end else begin
          bus.valid_i = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== lat[i] || busy_cnt !== lat[i]) begin
        failures++;
        $display("FAIL mul_latency[%0d]: edges=%0d busy_cycles=%0d, required %0d %0d",
                 i, n, busy_cnt, lat[i], lat[i]);
      end
      checks++;
      if (bus.valid_o !== 1'b1 || bus.data_o !== ev[i] || bus.zero_o !== (ev[i] == 32'd0)) begin
        failures++;
        $display("FAIL mul_result[%0d]: valid=%b data=%h zero=%b, required 1 %h %b",
                 i, bus.valid_o, bus.data_o, bus.zero_o, ev[i], ev[i] == 32'd0);
      end
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.data_o !== ev[i]) begin
        failures++;
        $display("FAIL mul_after[%0d]: valid=%b ready=%b data=%h, required 0 1 %h",
                 i, bus.valid_o, bus.ready_o, bus.data_o, ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int pulses = 0;
    bus.ALUCtrl_i = 3'b111; bus.data1_i = 32'd6; bus.data2_i = B_ABORT;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (bus.valid_o === 1'b1) pulses++;
      if (n == 9) rst = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bus.data_o !== 32'd0 || bus.zero_o !== 1'b1 || bus.valid_o !== 1'b0 ||
        bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mul: data=%h zero=%b valid=%b ready=%b busy=%b, required 00000000 1 0 1 0",
               bus.data_o, bus.zero_o, bus.valid_o, bus.ready_o, bus.busy_o);
    end
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_mul_pulses: valid_o pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    bus.ALUCtrl_i = 3'b010; bus.data1_i = 32'h1000; bus.data2_i = 32'h0234;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 32'h1234) begin
      failures++;
      $display("FAIL flush_setup: valid=%b data=%h, required 1 00001234", bus.valid_o, bus.data_o);
    end
    bus.ALUCtrl_i = 3'b111; bus.data1_i = 32'd6; bus.data2_i = B_ABORT;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (bus.valid_o === 1'b1) pulses++;
      if (n == 4) bus.flush_i = 1'b1;
      @(negedge clk);
    end
    bus.flush_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 ||
        bus.data_o !== 32'h1234 || bus.zero_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_mul: ready=%b busy=%b valid=%b data=%h zero=%b, required 1 0 0 00001234 0",
               bus.ready_o, bus.busy_o, bus.valid_o, bus.data_o, bus.zero_o);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL flush_mul_pulses: valid_o pulses=%0d, required 0", pulses);
    end
    bus.flush_i = 1'b1; bus.valid_i = 1'b1;
    bus.ALUCtrl_i = 3'b010; bus.data1_i = 32'd1; bus.data2_i = 32'd1;
    @(negedge clk);
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== 32'h1234 || bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle: valid=%b data=%h ready=%b, required 0 00001234 1",
               bus.valid_o, bus.data_o, bus.ready_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== 32'h1234) begin
      failures++;
      $display("FAIL flush_idle_after: valid=%b data=%h, required 0 00001234",
               bus.valid_o, bus.data_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    @(negedge clk);
    test_reset();
    test_single_cycle();
    test_back_to_back();
    test_mul();
    test_reset_mid_mul();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
